// File: rtl/blake2_msg_framer.sv
// rtl/blake2_msg_framer.sv - slices a byte stream into zero-padded 64-byte blocks for the blake2 core
module blake2_msg_framer #(
  parameter int BB    = 128,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [7:0]       s_data_i,
  input  logic             s_last_i,
  input  logic             s_empty_i,
  input  logic             core_ready_i,
  input  logic             core_h_v_i,
  output logic             data_v_o,
  output logic [IDX_W-1:0] data_idx_o,
  output logic [7:0]       data_o,
  output logic             block_first_o,
  output logic             block_last_o,
  output logic [BB-1:0]    ll_o
);

  typedef enum logic [2:0] {IDLE, DATA, PAD, WAIT_RES, DRAIN} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx_q;
  logic             first_q;
  logic [BB-1:0]    ll_q;

  logic in_stream;
  logic acc;
  logic empty_beat;
  logic idx_end;

  assign in_stream  = (state == IDLE) || (state == DATA);
  assign s_ready_o  = core_ready_i & in_stream;
  assign acc        = s_valid_i & s_ready_o;
  // s_empty_i only means something on the last beat; otherwise it is an ordinary byte
  assign empty_beat = s_last_i & s_empty_i;
  assign idx_end    = (idx_q == {IDX_W{1'b1}});

  always_comb begin
    data_v_o = 1'b0;
    data_o   = 8'h00;
    if (in_stream) begin
      data_v_o = acc & ~empty_beat;
      data_o   = data_v_o ? s_data_i : 8'h00;
    end else if (state == PAD) begin
      data_v_o = core_ready_i;
    end
  end

  assign data_idx_o    = idx_q;
  assign block_first_o = first_q | (state == IDLE);
  assign block_last_o  = (state == PAD) | (acc & s_last_i);
  assign ll_o          = ll_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state   <= IDLE;
      idx_q   <= '0;
      first_q <= 1'b0;
      ll_q    <= '0;
    end else begin
      if (data_v_o) idx_q <= idx_q + 1'b1;
      if (data_v_o && idx_end) first_q <= 1'b0;
      case (state)
        IDLE: begin
          if (acc) begin
            first_q <= 1'b1;
            ll_q    <= empty_beat ? '0 : BB'(1);
            state   <= s_last_i ? PAD : DATA;
          end
        end
        DATA: begin
          if (acc) begin
            if (!empty_beat) ll_q <= ll_q + 1'b1;
            // a final byte landing exactly on idx 63 needs no padding
            if (s_last_i) state <= (data_v_o && idx_end) ? WAIT_RES : PAD;
          end
        end
        PAD: begin
          if (data_v_o && idx_end) state <= WAIT_RES;
        end
        WAIT_RES: begin
          if (core_h_v_i) state <= DRAIN;
        end
        DRAIN: begin
          if (!core_h_v_i) begin
            state <= IDLE;
            idx_q <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blake2_msg_framer.sv
// tb/tb_blake2_msg_framer.sv - randomized self-checking bench for blake2_msg_framer
module tb_blake2_msg_framer;

  localparam int BB    = 128;
  localparam int IDX_W = 6;

  logic             clk;
  logic             nreset;
  logic             s_valid;
  logic             s_ready;
  logic [7:0]       s_data;
  logic             s_last;
  logic             s_empty;
  logic             core_ready;
  logic             core_h_v;
  logic             data_v;
  logic [IDX_W-1:0] data_idx;
  logic [7:0]       data;
  logic             block_first;
  logic             block_last;
  logic [BB-1:0]    ll;

  int n_tests;
  int n_fail;
  logic [7:0] msg [0:255];

  blake2_msg_framer #(.BB(BB), .IDX_W(IDX_W)) dut (
    .clk(clk), .nreset(nreset),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .s_last_i(s_last), .s_empty_i(s_empty),
    .core_ready_i(core_ready), .core_h_v_i(core_h_v),
    .data_v_o(data_v), .data_idx_o(data_idx), .data_o(data),
    .block_first_o(block_first), .block_last_o(block_last), .ll_o(ll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BB-1:0] got, input logic [BB-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Streams msg[0:n-1] (n==0: one empty beat) and checks every strobe against the
  // block layout the message should produce. stall: hold core_ready low for 100
  // cycles after strobe 63. abort_at >= 0: return right after that strobe.
  task automatic run_msg(input int n, input bit stall, input int abort_at);
    int nblk, total, nbeats, pos, strobe, stall_cnt, d, hold;
    bit done;
    logic [15:0] exp_s;
    nblk      = (n == 0) ? 1 : (n + 63) / 64;
    total     = 64 * nblk;
    nbeats    = (n == 0) ? 1 : n;
    pos       = 0;
    strobe    = 0;
    stall_cnt = 0;
    d         = 0;
    hold      = $urandom_range(1, 5);
    done      = 1'b0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(posedge clk); #1;
      s_valid = (pos < nbeats) && ($urandom_range(0, 3) != 0);
      s_data  = (pos < n) ? msg[pos] : 8'($urandom);
      s_last  = (pos == nbeats - 1);
      s_empty = (n == 0) || (!s_last && $urandom_range(0, 7) == 0);
      if (stall_cnt > 0)      core_ready = 1'b0;
      else if (strobe >= total || stall) core_ready = 1'b1;
      else                    core_ready = ($urandom_range(0, 4) != 0);
      core_h_v = (strobe >= total) && (d >= hold) && (d < hold + 33);
      @(negedge clk);
      if (strobe >= total) begin
        if (d < hold + 34) begin
          check("hold_ready", s_ready, 0);
          check("hold_strobe", data_v, 0);
          check("hold_ll", ll, BB'(n));
        end else begin
          check("restart_ready", s_ready, 1);
          check("restart_idx", data_idx, 0);
          check("restart_first", block_first, 1);
          done = 1'b1;
        end
        d++;
      end else begin
        if (stall_cnt > 0) begin
          check("stall_strobe", data_v, 0);
          check("stall_ready", s_ready, 0);
          check("stall_idx", data_idx, 0);
          stall_cnt--;
        end else if (pos < nbeats) begin
          check("ready_stream", s_ready, core_ready);
        end else begin
          check("ready_pad", s_ready, 0);
        end
        if (data_v) begin
          exp_s[15:10] = 6'(strobe % 64);
          exp_s[9:2]   = (strobe < n) ? msg[strobe] : 8'h00;
          exp_s[1]     = (strobe < 64);
          exp_s[0]     = (n == 0) || (strobe >= n - 1);
          check($sformatf("strobe%0d{idx,data,first,last}", strobe),
                {data_idx, data, block_first, block_last}, exp_s);
          if (strobe >= n) check("pad_ll", ll, BB'(n));
          if (stall && strobe == 63) stall_cnt = 100;
          if (strobe == abort_at) return;
          strobe++;
        end
        if (s_valid && s_ready) pos++;
      end
    end
    if (!done) check("timeout", 0, 1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    nreset = 1'b0; s_valid = 0; s_data = 0; s_last = 0; s_empty = 0;
    core_ready = 0; core_h_v = 0;
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    @(negedge clk);
    check("rst_data_v", data_v, 0);
    check("rst_ready", s_ready, 0);
    check("rst_data", data, 0);
    check("rst_idx", data_idx, 0);
    check("rst_last", block_last, 0);
    check("rst_first", block_first, 1);
    check("rst_ll", ll, 0);

    run_msg(0, 0, -1);
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    run_msg(3, 0, -1);
    for (int i = 0; i < 65; i++) msg[i] = 8'(i);
    run_msg(64, 0, -1);
    msg[64] = 8'hA5;
    run_msg(65, 1, -1);

    for (int i = 0; i < 5; i++) msg[i] = 8'($urandom);
    run_msg(5, 0, 20);
    @(posedge clk); #1;
    nreset = 1'b0; s_valid = 1'b0; core_ready = 1'b1;
    @(posedge clk); #1;
    nreset = 1'b1;
    @(negedge clk);
    check("rstpad_data_v", data_v, 0);
    check("rstpad_ll", ll, 0);
    check("rstpad_idx", data_idx, 0);
    check("rstpad_first", block_first, 1);
    msg[0] = 8'h5A;
    run_msg(1, 0, -1);

    foreach (msg[i]) msg[i] = 8'($urandom);
    run_msg(63, 0, -1);
    run_msg(127, 0, -1);
    run_msg(128, 0, -1);
    run_msg(0, 0, -1);
    for (int t = 0; t < 4; t++) begin
      foreach (msg[i]) msg[i] = 8'($urandom);
      run_msg($urandom_range(1, 200), 0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
